// File: rtl/tia_audio_synth_if.sv
// Register strobe bus shared with the TIA decoder; AUDC/AUDF/AUDV addresses arrive rebased to 0.
interface tia_audio_synth_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;

    // stb_i is the valid for we_i/adr_i/dat_i and is always accepted (no ready);
    // a read returns its data in dat_o on the following cycle, which then holds.
    modport master (output stb_i, we_i, adr_i, dat_i, input dat_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o);
endinterface

// File: rtl/tia_audio_synth.sv
// NUM_CH TIA-style audio channels: AUDC waveform modes over poly4/5/9 LFSRs and divide
// chains, AUDF frequency division, AUDV volume, PCM mix and per-channel sigma-delta bits.
module tia_audio_synth #(
    parameter int NUM_CH     = 2,
    parameter int CLK_DIV    = 114,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MIX_W      = 4 + $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    tia_audio_synth_if.slave        bus,
    output logic [4*NUM_CH-1:0]     level_o,
    output logic [MIX_W-1:0]        mix_o,
    output logic [NUM_CH-1:0]       pdm_o
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [MIX_W-1:0]      mix_q, mix_d;
    logic [NUM_CH-1:0]     pdm_q, pdm_d;
    logic [NUM_CH-1:0]     cclk;

    logic [3:0] audc_q [NUM_CH];
    logic [3:0] audc_d [NUM_CH];
    logic [4:0] audf_q [NUM_CH];
    logic [4:0] audf_d [NUM_CH];
    logic [3:0] audv_q [NUM_CH];
    logic [3:0] audv_d [NUM_CH];
    logic [4:0] fcnt_q [NUM_CH];
    logic [4:0] fcnt_d [NUM_CH];
    logic [3:0] p4_q   [NUM_CH];
    logic [3:0] p4_d   [NUM_CH];
    logic [4:0] p5_q   [NUM_CH];
    logic [4:0] p5_d   [NUM_CH];
    logic [8:0] p9_q   [NUM_CH];
    logic [8:0] p9_d   [NUM_CH];
    logic [4:0] div_q  [NUM_CH];
    logic [4:0] div_d  [NUM_CH];
    logic [1:0] d3_q   [NUM_CH];
    logic [1:0] d3_d   [NUM_CH];
    logic       out_q  [NUM_CH];
    logic       out_d  [NUM_CH];
    logic [3:0] lvl_q  [NUM_CH];
    logic [3:0] lvl_d  [NUM_CH];
    logic [3:0] acc_q  [NUM_CH];
    logic [3:0] acc_d  [NUM_CH];
    logic [4:0] acc_sum[NUM_CH];

    logic unused_dat;
    assign unused_dat = ^bus.dat_i[DATA_WIDTH-1:5];

    function automatic logic [3:0] step4(input logic [3:0] p);
        return {p[2:0], p[3] ^ p[2]};
    endfunction

    function automatic logic [4:0] step5(input logic [4:0] p);
        return {p[3:0], p[4] ^ p[2]};
    endfunction

    function automatic logic [8:0] step9(input logic [8:0] p);
        return {p[7:0], p[8] ^ p[4]};
    endfunction

    function automatic logic [4:0] div31(input logic [4:0] d);
        return (d >= 5'd30) ? 5'd0 : d + 5'd1;
    endfunction

    function automatic logic [1:0] div3(input logic [1:0] d);
        return (d >= 2'd2) ? 2'd0 : d + 2'd1;
    endfunction

    always_comb begin
        tick    = enable_i && (presc_q == PW'(CLK_DIV - 1));
        presc_d = presc_q;
        if (enable_i) presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Register file: address = sel*NUM_CH + ch; unmatched addresses fall through and read 0.
    always_comb begin
        dat_d = dat_q;
        if (bus.stb_i && !bus.we_i) dat_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            audc_d[c] = audc_q[c];
            audf_d[c] = audf_q[c];
            audv_d[c] = audv_q[c];
            if (bus.stb_i && int'(bus.adr_i) == c) begin
                if (bus.we_i) audc_d[c] = bus.dat_i[3:0];
                else          dat_d     = DATA_WIDTH'(audc_q[c]);
            end
            if (bus.stb_i && int'(bus.adr_i) == NUM_CH + c) begin
                if (bus.we_i) audf_d[c] = bus.dat_i[4:0];
                else          dat_d     = DATA_WIDTH'(audf_q[c]);
            end
            if (bus.stb_i && int'(bus.adr_i) == 2*NUM_CH + c) begin
                if (bus.we_i) audv_d[c] = bus.dat_i[3:0];
                else          dat_d     = DATA_WIDTH'(audv_q[c]);
            end
        end
    end

    always_comb begin
        pdm_d = '0;
        mix_d = '0;
        cclk  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fcnt_d[c] = fcnt_q[c];
            p4_d[c]   = p4_q[c];
            p5_d[c]   = p5_q[c];
            p9_d[c]   = p9_q[c];
            div_d[c]  = div_q[c];
            d3_d[c]   = d3_q[c];
            out_d[c]  = out_q[c];
            // >= rather than == so a lowered AUDF wraps on the very next tick.
            cclk[c] = tick && (fcnt_q[c] >= audf_q[c]);
            if (tick) fcnt_d[c] = cclk[c] ? 5'd0 : fcnt_q[c] + 5'd1;
            if (cclk[c]) begin
                case (audc_q[c])
                    4'd0, 4'd11: out_d[c] = 1'b1;
                    4'd1: begin
                        p4_d[c]  = step4(p4_q[c]);
                        out_d[c] = p4_d[c][3];
                    end
                    4'd2: begin
                        if (div_q[c] >= 5'd14) begin
                            div_d[c] = 5'd0;
                            p4_d[c]  = step4(p4_q[c]);
                        end else begin
                            div_d[c] = div_q[c] + 5'd1;
                        end
                        out_d[c] = p4_d[c][3];
                    end
                    4'd3: begin
                        p5_d[c] = step5(p5_q[c]);
                        if (p5_d[c][4]) p4_d[c] = step4(p4_q[c]);
                        out_d[c] = p4_d[c][3];
                    end
                    4'd4, 4'd5: out_d[c] = ~out_q[c];
                    4'd6, 4'd10: begin
                        div_d[c] = div31(div_q[c]);
                        out_d[c] = (div_d[c] < 5'd13);
                    end
                    4'd7, 4'd9: begin
                        p5_d[c]  = step5(p5_q[c]);
                        out_d[c] = p5_d[c][4];
                    end
                    4'd8: begin
                        p9_d[c]  = step9(p9_q[c]);
                        out_d[c] = p9_d[c][8];
                    end
                    4'd12, 4'd13: begin
                        d3_d[c] = div3(d3_q[c]);
                        if (d3_q[c] >= 2'd2) out_d[c] = ~out_q[c];
                    end
                    4'd14: begin
                        d3_d[c] = div3(d3_q[c]);
                        if (d3_q[c] >= 2'd2) div_d[c] = div31(div_q[c]);
                        out_d[c] = (div_d[c] < 5'd13);
                    end
                    default: begin
                        p5_d[c] = step5(p5_q[c]);
                        if (p5_d[c][4]) begin
                            d3_d[c] = div3(d3_q[c]);
                            if (d3_q[c] >= 2'd2) out_d[c] = ~out_q[c];
                        end
                    end
                endcase
            end
            lvl_d[c]   = out_d[c] ? audv_q[c] : 4'd0;
            acc_sum[c] = {1'b0, acc_q[c]} + {1'b0, lvl_q[c]};
            acc_d[c]   = acc_sum[c][3:0];
            pdm_d[c]   = acc_sum[c][4];
            mix_d      = mix_d + MIX_W'(lvl_q[c]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            dat_q   <= '0;
            mix_q   <= '0;
            pdm_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                audc_q[c] <= '0;
                audf_q[c] <= '0;
                audv_q[c] <= '0;
                fcnt_q[c] <= '0;
                p4_q[c]   <= 4'hF;
                p5_q[c]   <= 5'h1F;
                p9_q[c]   <= 9'h1FF;
                div_q[c]  <= '0;
                d3_q[c]   <= '0;
                out_q[c]  <= 1'b0;
                lvl_q[c]  <= '0;
                acc_q[c]  <= '0;
            end
        end else begin
            presc_q <= presc_d;
            dat_q   <= dat_d;
            mix_q   <= mix_d;
            pdm_q   <= pdm_d;
            audc_q  <= audc_d;
            audf_q  <= audf_d;
            audv_q  <= audv_d;
            fcnt_q  <= fcnt_d;
            p4_q    <= p4_d;
            p5_q    <= p5_d;
            p9_q    <= p9_d;
            div_q   <= div_d;
            d3_q    <= d3_d;
            out_q   <= out_d;
            lvl_q   <= lvl_d;
            acc_q   <= acc_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_level
        assign level_o[4*g +: 4] = lvl_q[g];
    end

    assign bus.dat_o = dat_q;
    assign mix_o     = mix_q;
    assign pdm_o     = pdm_q;
endmodule

// File: tb/tb_tia_audio_synth.sv
// Directed bench for tia_audio_synth: a 2-channel and a 4-channel instance with CLK_DIV=4.
module tb_tia_audio_synth;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  level_a;
    logic [4:0]  mix_a;
    logic [1:0]  pdm_a;
    logic [15:0] level_b;
    logic [5:0]  mix_b;
    logic [3:0]  pdm_b;

    logic [31:0] exp_q[$];
    int          n_chk;
    int          n_pass;
    logic        seq [0:1199];

    tia_audio_synth_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_a ();
    tia_audio_synth_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_b ();

    tia_audio_synth #(.NUM_CH(2), .CLK_DIV(4)) u_a (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_a),
        .level_o(level_a), .mix_o(mix_a), .pdm_o(pdm_a)
    );

    tia_audio_synth #(.NUM_CH(4), .CLK_DIV(4)) u_b (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_b),
        .level_o(level_b), .mix_o(mix_b), .pdm_o(pdm_b)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drivers
    task automatic wr_a(input int a, input int d);
        bus_a.adr_i = 4'(a);
        bus_a.dat_i = 8'(d);
        bus_a.we_i  = 1'b1;
        bus_a.stb_i = 1'b1;
        step();
        bus_a.stb_i = 1'b0;
        bus_a.we_i  = 1'b0;
    endtask

    task automatic rd_a(input string tag, input int a, input logic [7:0] e);
        bus_a.adr_i = 4'(a);
        bus_a.we_i  = 1'b0;
        bus_a.stb_i = 1'b1;
        exp_q.push_back(32'(e));
        step();
        bus_a.stb_i = 1'b0;
        chk(tag, 32'(bus_a.dat_o), exp_q.pop_front());
    endtask

    task automatic wr_b(input int a, input int d);
        bus_b.adr_i = 4'(a);
        bus_b.dat_i = 8'(d);
        bus_b.we_i  = 1'b1;
        bus_b.stb_i = 1'b1;
        step();
        bus_b.stb_i = 1'b0;
        bus_b.we_i  = 1'b0;
    endtask

    task automatic rd_b(input string tag, input int a, input logic [7:0] e);
        bus_b.adr_i = 4'(a);
        bus_b.we_i  = 1'b0;
        bus_b.stb_i = 1'b1;
        exp_q.push_back(32'(e));
        step();
        bus_b.stb_i = 1'b0;
        chk(tag, 32'(bus_b.dat_o), exp_q.pop_front());
    endtask

    // Observers
    task automatic wait_change(input int max, output int cnt);
        logic [3:0] prev;
        prev = level_a[3:0];
        cnt  = -1;
        for (int i = 1; i <= max && cnt < 0; i++) begin
            step();
            if (level_a[3:0] != prev) cnt = i;
        end
    endtask

    task automatic count_changes(input int n, output int cnt);
        logic [3:0] prev;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            prev = level_a[3:0];
            step();
            if (level_a[3:0] != prev) cnt++;
        end
    endtask

    task automatic count_pdm(input int ch, input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pdm_a[ch]) ones++;
        end
    endtask

    // One sample per channel clock (AUDF=0, CLK_DIV=4), then period and duty checks.
    task automatic measure(input string tag, input int p, input int ones_exp, input int n);
        int mism;
        int ones;
        for (int i = 0; i < n; i++) begin
            steps(4);
            seq[i] = (level_a[3:0] != 4'd0);
        end
        mism = 0;
        ones = 0;
        for (int i = 0; i < n - p; i++) if (seq[i] != seq[i+p]) mism++;
        for (int i = 0; i < p; i++) if (seq[i]) ones++;
        chk({tag, "_period"}, 32'(mism), 32'd0);
        chk({tag, "_ones"}, 32'(ones), 32'(ones_exp));
    endtask

    initial begin
        int c;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        enable = 1'b0;
        bus_a.stb_i = 1'b0; bus_a.we_i = 1'b0; bus_a.adr_i = '0; bus_a.dat_i = '0;
        bus_b.stb_i = 1'b0; bus_b.we_i = 1'b0; bus_b.adr_i = '0; bus_b.dat_i = '0;
        steps(3);
        rst = 1'b0;
        step();

        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_mix", 32'(mix_a), 32'd0);
        chk("rst_pdm", 32'(pdm_a), 32'd0);
        chk("rst_dat", 32'(bus_a.dat_o), 32'd0);
        for (int a = 0; a < 6; a++) rd_a("rd_reset", a, 8'd0);
        rd_a("rd_unmapped", 6, 8'd0);

        wr_a(0, 'hA4); rd_a("rd_audc", 0, 8'd4);
        wr_a(3, 'hFF); rd_a("rd_audf", 3, 8'd31);
        wr_a(5, 'h3C); rd_a("rd_audv", 5, 8'd12);
        wr_a(6, 'hFF); rd_a("rd_unmapped_wr", 6, 8'd0);
        rd_a("rd_audv_again", 5, 8'd12);
        steps(3);
        chk("dat_hold", 32'(bus_a.dat_o), 32'd12);
        wr_a(2, 0);
        chk("dat_hold_wr", 32'(bus_a.dat_o), 32'd12);

        for (int a = 8; a < 12; a++) wr_b(a, 15);
        rd_b("rd_b_audv3", 11, 8'd15);

        // Square wave: AUDC=4, AUDF=0, AUDV=9, ticks every 4 clocks from enable.
        wr_a(0, 4); wr_a(2, 0); wr_a(4, 9); wr_a(5, 0);
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            exp_q.push_back(((k / 4) % 2 == 1) ? 32'd9 : 32'd0);
            exp_q.push_back((((k - 1) / 4) % 2 == 1) ? 32'd9 : 32'd0);
            step();
            chk("tog_level", 32'(level_a[3:0]), exp_q.pop_front());
            chk("tog_mix", 32'(mix_a), exp_q.pop_front());
        end

        wr_a(4, 15);
        wr_a(0, 8); steps(8); measure("mode8", 511, 256, 1042);
        wr_a(0, 1); steps(8); measure("mode1", 15, 8, 50);
        wr_a(0, 7); steps(8); measure("mode7", 31, 16, 80);
        wr_a(0, 6); steps(8); measure("mode6", 31, 13, 80);

        wr_a(0, 4); wr_a(2, 31);
        steps(200);
        count_changes(512, c);
        chk("audf31_cclks", 32'(c), 32'd4);
        wait_change(300, c);
        chk("audf31_sync", 32'(c > 0 && c <= 128), 32'd1);
        steps(80);
        wr_a(2, 2);
        wait_change(20, c);
        chk("audf_wrap", 32'(c), 32'd3);
        wait_change(30, c);
        chk("audf2_period", 32'(c), 32'd12);
        enable = 1'b0;
        count_changes(50, c);
        chk("enable_hold", 32'(c), 32'd0);
        enable = 1'b1;
        wait_change(30, c);
        chk("enable_resume", 32'(c), 32'd12);

        wr_a(0, 0); wr_a(4, 8);
        steps(30);
        count_pdm(0, 16, c);
        chk("pdm_v8", 32'(c), 32'd8);
        chk("mix_v8", 32'(mix_a), 32'd8);
        count_pdm(1, 16, c);
        chk("pdm_ch1_silent", 32'(c), 32'd0);
        wr_a(4, 15); steps(6);
        count_pdm(0, 16, c);
        chk("pdm_v15", 32'(c), 32'd15);
        wr_a(4, 0); steps(6);
        count_pdm(0, 16, c);
        chk("pdm_v0", 32'(c), 32'd0);

        wr_a(4, 15); steps(4);
        rd_a("rd_v15", 4, 8'd15);
        chk("pre_rst_level", 32'(level_a[3:0]), 32'd15);
        chk("pre_rst_mix", 32'(mix_a), 32'd15);
        chk("b_mix60", 32'(mix_b), 32'd60);
        chk("b_level", 32'(level_b), 32'hFFFF);

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(level_a), 32'd0);
        chk("async_mix", 32'(mix_a), 32'd0);
        chk("async_pdm", 32'(pdm_a), 32'd0);
        chk("async_dat", 32'(bus_a.dat_o), 32'd0);
        chk("async_b_mix", 32'(mix_b), 32'd0);
        chk("async_b_level", 32'(level_b), 32'd0);
        enable = 1'b0;
        steps(2);
        rst = 1'b0;
        step();
        rd_a("post_rst_audv", 4, 8'd0);
        rd_a("post_rst_audf", 3, 8'd0);

        // Reseeded poly9 yields eight ones then the first feedback zero.
        wr_a(0, 8); wr_a(4, 15);
        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back((k <= 8) ? 32'd15 : 32'd0);
            steps(4);
            chk("reseed_poly9", 32'(level_a[3:0]), exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
